// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Sequencer for a multicycle RV32I core. Each instruction takes several cycles
// through a shared ALU, register file, instruction register and one unified
// memory port. Datapath controls are Moore-decoded from the current state.
// A few strobes are also gated by the memory handshake (mem_ready) or by the
// branch-condition input. The ImmSrc, ALUOp and ResultSrc encodings are the
// same as the single-cycle decoder's.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   op             opcode held in the instruction register
//   branch_cond    branch taken, computed outside from funct3 and ALU flags
//   mem_ready      memory finishes the current access in this cycle
//   mem_req        memory access request (held until mem_ready)
//   MemWrite       store strobe
//   AdrSrc         memory address select: 0 = PC, 1 = ALUOut
//   IRWrite        latch instruction and OldPC
//   PCWrite        PC load enable
//   RegWrite       register file write enable
//   ResultSrc      00 ALUOut, 01 read data, 10 ALUResult
//   ALUSrcA        00 PC, 01 OldPC, 10 rs1
//   ALUSrcB        00 rs2, 01 imm, 10 constant 4
//   ImmSrc         immediate format (000 I, 001 S, 010 B, 011 U, 100 J)
//   ALUOp          000 add, 001 branch cmp, 010 funct, 011 add & clr LSB,
//                  100 pass B
//   instr_retired  one-cycle pulse in the final cycle of each instruction
//   retire_count   number of instructions retired since reset (wraps)
//   illegal_op     sticky flag, set once an unsupported opcode is decoded
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int OP_WIDTH      = 7,
    parameter int IMM_SRC_WIDTH = 3,
    parameter int ALU_OP_WIDTH  = 3,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OP_WIDTH-1:0]      op,
    input  logic                     branch_cond,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     MemWrite,
    output logic                     AdrSrc,
    output logic                     IRWrite,
    output logic                     PCWrite,
    output logic                     RegWrite,
    output logic [1:0]               ResultSrc,
    output logic [1:0]               ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [IMM_SRC_WIDTH-1:0] ImmSrc,
    output logic [ALU_OP_WIDTH-1:0]  ALUOp,
    output logic                     instr_retired,
    output logic [CNT_WIDTH-1:0]     retire_count,
    output logic                     illegal_op
);

    // RV32I opcodes
    localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_RTYPE  = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_ITYPE  = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);
    localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);
    localparam logic [OP_WIDTH-1:0] OP_JALR   = OP_WIDTH'(7'b1100111);
    localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(7'b0110111);
    localparam logic [OP_WIDTH-1:0] OP_AUIPC  = OP_WIDTH'(7'b0010111);

    // Select encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = ALU_OP_WIDTH'(3'b000);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BRCMP  = ALU_OP_WIDTH'(3'b001);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_FUNCT  = ALU_OP_WIDTH'(3'b010);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADDCLR = ALU_OP_WIDTH'(3'b011);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_PASSB  = ALU_OP_WIDTH'(3'b100);

    localparam logic [IMM_SRC_WIDTH-1:0] IMM_I = IMM_SRC_WIDTH'(3'b000);
    localparam logic [IMM_SRC_WIDTH-1:0] IMM_S = IMM_SRC_WIDTH'(3'b001);
    localparam logic [IMM_SRC_WIDTH-1:0] IMM_B = IMM_SRC_WIDTH'(3'b010);
    localparam logic [IMM_SRC_WIDTH-1:0] IMM_U = IMM_SRC_WIDTH'(3'b011);
    localparam logic [IMM_SRC_WIDTH-1:0] IMM_J = IMM_SRC_WIDTH'(3'b100);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR,
        S_JALR_JMP, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    state_t state;

    // The last cycle of each instruction. A store completes only when memory
    // accepts the write.
    logic retire;
    assign retire = (state == S_MEMWB) || (state == S_ALUWB) ||
                    (state == S_BRANCH) ||
                    ((state == S_MEMWRITE) && mem_ready);

    // -----------------------------------------------------------------------
    // State register and retired-instruction counter
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // in this block samples its inputs from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            retire_count <= '0;
        end else begin
            if (retire) begin
                retire_count <= retire_count + 1'b1;   // wraps naturally
            end
            unique case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (op == OP_LOAD || op == OP_STORE) state <= S_MEMADR;
                    else if (op == OP_RTYPE)             state <= S_EXECR;
                    else if (op == OP_ITYPE)             state <= S_EXECI;
                    else if (op == OP_BRANCH)            state <= S_BRANCH;
                    else if (op == OP_JAL)               state <= S_JAL;
                    else if (op == OP_JALR)              state <= S_JALR_ADR;
                    else if (op == OP_LUI)               state <= S_LUI;
                    else if (op == OP_AUIPC)             state <= S_AUIPC;
                    else                                 state <= S_TRAP;
                end
                S_MEMADR:   state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_JALR_ADR: state <= S_JALR_JMP;
                S_JALR_JMP: state <= S_ALUWB;
                S_LUI:      state <= S_ALUWB;
                S_AUIPC:    state <= S_ALUWB;
                S_TRAP:     state <= S_TRAP;                 // held until reset
                default:    state <= S_FETCH;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. The outputs depend on state plus the handshake and branch
    // inputs. They are forced low while reset is asserted, so an access cut
    // off by reset drops its strobes at once.
    // -----------------------------------------------------------------------
    // NOTE: every output gets a default value before the case statement.
    // This means no path leaves an output unassigned and no latch is inferred.
    always_comb begin
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RS2;
        ImmSrc        = IMM_I;
        ALUOp         = ALU_ADD;
        instr_retired = 1'b0;
        illegal_op    = 1'b0;

        if (rst_n) begin
            // The immediate format depends only on the opcode, never on state.
            if (op == OP_STORE)                     ImmSrc = IMM_S;
            else if (op == OP_BRANCH)               ImmSrc = IMM_B;
            else if (op == OP_LUI || op == OP_AUIPC) ImmSrc = IMM_U;
            else if (op == OP_JAL)                  ImmSrc = IMM_J;

            instr_retired = retire;

            unique case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;                  // PC+4 into PC
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin                              // OldPC+imm
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = RES_RDATA;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALU_FUNCT;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALU_FUNCT;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALU_BRCMP;
                    PCWrite = branch_cond;                   // target in ALUOut
                end
                // JAL and JALR_JMP load the target from ALUOut into PC. At the
                // same time they compute OldPC+4, which ALUWB writes as the
                // link address.
                S_JAL, S_JALR_JMP: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
                S_JALR_ADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALU_ADDCLR;
                end
                S_LUI: begin
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALU_PASSB;
                end
                S_AUIPC: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                S_TRAP: begin
                    illegal_op = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// Testbench for multicycle_control_fsm.
// Each cycle, the expected control vector is built from the opcode's
// documented state sequence and pushed to a scoreboard queue. It is popped
// and compared at the falling edge. The retire count and the reset
// behaviour are compared inline.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [2:0] alu_op;
        logic       instr_retired;
        logic       illegal_op;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic        branch_cond;
    logic        mem_ready;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc, ALUOp;
    logic        instr_retired;
    logic [31:0] retire_count;
    logic        illegal_op;

    ctl_t  act;
    ctl_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .branch_cond(branch_cond),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUOp(ALUOp),
        .instr_retired(instr_retired), .retire_count(retire_count),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp,
                  instr_retired, illegal_op};

    // Expected control vectors for each state (im = ImmSrc of the opcode)
    function automatic ctl_t base(input logic [2:0] im);
        ctl_t c = '0;
        c.imm_src = im;
        return c;
    endfunction
    function automatic ctl_t e_fetch(input logic rdy, input logic [2:0] im);
        ctl_t c = base(im);
        c.mem_req = 1'b1; c.ir_write = rdy; c.pc_write = rdy;
        c.result_src = 2'b10; c.alu_src_b = 2'b10;
        return c;
    endfunction
    function automatic ctl_t e_decode(input logic [2:0] im);
        ctl_t c = base(im);
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b01;
        return c;
    endfunction
    function automatic ctl_t e_memadr(input logic [2:0] im);
        ctl_t c = base(im);
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
        return c;
    endfunction
    function automatic ctl_t e_memread();
        ctl_t c = base(3'b000);
        c.mem_req = 1'b1; c.adr_src = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_memwb();
        ctl_t c = base(3'b000);
        c.result_src = 2'b01; c.reg_write = 1'b1; c.instr_retired = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_memwrite(input logic rdy);
        ctl_t c = base(3'b001);
        c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1;
        c.instr_retired = rdy;
        return c;
    endfunction
    function automatic ctl_t e_exec(input logic imm_b, input logic [2:0] im);
        ctl_t c = base(im);
        c.alu_src_a = 2'b10; c.alu_src_b = imm_b ? 2'b01 : 2'b00;
        c.alu_op = 3'b010;
        return c;
    endfunction
    function automatic ctl_t e_aluwb(input logic [2:0] im);
        ctl_t c = base(im);
        c.reg_write = 1'b1; c.instr_retired = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_branch(input logic bc);
        ctl_t c = base(3'b010);
        c.alu_src_a = 2'b10; c.alu_op = 3'b001; c.pc_write = bc;
        c.instr_retired = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_jump(input logic [2:0] im);
        ctl_t c = base(im);
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_jalr_adr();
        ctl_t c = base(3'b000);
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 3'b011;
        return c;
    endfunction
    function automatic ctl_t e_lui();
        ctl_t c = base(3'b011);
        c.alu_src_b = 2'b01; c.alu_op = 3'b100;
        return c;
    endfunction
    function automatic ctl_t e_auipc();
        ctl_t c = base(3'b011);
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b01;
        return c;
    endfunction
    function automatic ctl_t e_trap();
        ctl_t c = base(3'b000);
        c.illegal_op = 1'b1;
        return c;
    endfunction

    // Compare the oldest expected vector against the outputs at the falling
    // edge. The clock keeps running, so this always completes.
    task automatic compare_front();
        ctl_t  e;
        string nm;
        @(negedge clk);
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outputs, then check them
    task automatic drive(input logic [6:0] o, input logic rdy, input logic bc,
                         input ctl_t e, input string nm);
        op = o; mem_ready = rdy; branch_cond = bc;
        exp_q.push_back(e);
        name_q.push_back(nm);
        compare_front();
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input logic [31:0] expv, input string nm);
        checks++;
        if (retire_count !== expv) begin
            errors++;
            $display("FAIL %s: retire_count got %0d expected %0d",
                     nm, retire_count, expv);
        end
    endtask

    task automatic check_quiet(input string nm);
        checks++;
        if (act !== ctl_t'('0)) begin
            errors++;
            $display("FAIL %s: outputs got %h expected 0", nm, act);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = OP_RTYPE; mem_ready = 1'b1; branch_cond = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset_outputs");
        check_count(32'd0, "reset_count");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        drive(OP_RTYPE, 1, 0, e_fetch(1, 3'b000), "add_fetch");
        drive(OP_RTYPE, 1, 0, e_decode(3'b000),   "add_decode");
        drive(OP_RTYPE, 1, 0, e_exec(0, 3'b000),  "add_execr");
        drive(OP_RTYPE, 1, 0, e_aluwb(3'b000),    "add_aluwb");
        check_count(32'd1, "add_count");
    endtask

    task automatic test_load_stall();
        drive(OP_LOAD, 1, 0, e_fetch(1, 3'b000), "lw_fetch");
        drive(OP_LOAD, 1, 0, e_decode(3'b000),   "lw_decode");
        drive(OP_LOAD, 1, 0, e_memadr(3'b000),   "lw_memadr");
        drive(OP_LOAD, 0, 0, e_memread(),        "lw_memread_wait1");
        drive(OP_LOAD, 0, 0, e_memread(),        "lw_memread_wait2");
        drive(OP_LOAD, 1, 0, e_memread(),        "lw_memread_done");
        drive(OP_LOAD, 1, 0, e_memwb(),          "lw_memwb");
        check_count(32'd2, "lw_count");
    endtask

    task automatic test_branch();
        drive(OP_BRANCH, 1, 1, e_fetch(1, 3'b010), "beq_t_fetch");
        drive(OP_BRANCH, 1, 1, e_decode(3'b010),   "beq_t_decode");
        drive(OP_BRANCH, 1, 1, e_branch(1),        "beq_t_branch");
        drive(OP_BRANCH, 1, 0, e_fetch(1, 3'b010), "beq_nt_fetch");
        drive(OP_BRANCH, 1, 0, e_decode(3'b010),   "beq_nt_decode");
        drive(OP_BRANCH, 1, 0, e_branch(0),        "beq_nt_branch");
        check_count(32'd4, "beq_count");
    endtask

    task automatic test_jalr();
        drive(OP_JALR, 1, 0, e_fetch(1, 3'b000), "jalr_fetch");
        drive(OP_JALR, 1, 0, e_decode(3'b000),   "jalr_decode");
        drive(OP_JALR, 1, 0, e_jalr_adr(),       "jalr_adr");
        drive(OP_JALR, 1, 0, e_jump(3'b000),     "jalr_jmp");
        drive(OP_JALR, 1, 0, e_aluwb(3'b000),    "jalr_aluwb");
        check_count(32'd5, "jalr_count");
    endtask

    task automatic test_back_to_back();
        drive(OP_STORE, 1, 0, e_fetch(1, 3'b001), "sw_fetch");
        drive(OP_STORE, 1, 0, e_decode(3'b001),   "sw_decode");
        drive(OP_STORE, 1, 0, e_memadr(3'b001),   "sw_memadr");
        drive(OP_STORE, 1, 0, e_memwrite(1),      "sw_memwrite");
        drive(OP_LUI,   1, 0, e_fetch(1, 3'b011), "lui_fetch");
        drive(OP_LUI,   1, 0, e_decode(3'b011),   "lui_decode");
        drive(OP_LUI,   1, 0, e_lui(),            "lui_exec");
        drive(OP_LUI,   1, 0, e_aluwb(3'b011),    "lui_aluwb");
        drive(OP_JAL,   1, 0, e_fetch(1, 3'b100), "jal_fetch");
        drive(OP_JAL,   1, 0, e_decode(3'b100),   "jal_decode");
        drive(OP_JAL,   1, 0, e_jump(3'b100),     "jal_jump");
        drive(OP_JAL,   1, 0, e_aluwb(3'b100),    "jal_aluwb");
        // A fetch stall, then mem_ready low in DECODE, which must be ignored
        drive(OP_ITYPE, 0, 0, e_fetch(0, 3'b000), "addi_fetch_stall");
        drive(OP_ITYPE, 1, 0, e_fetch(1, 3'b000), "addi_fetch");
        drive(OP_ITYPE, 0, 0, e_decode(3'b000),   "addi_decode_norq");
        drive(OP_ITYPE, 1, 0, e_exec(1, 3'b000),  "addi_execi");
        drive(OP_ITYPE, 1, 0, e_aluwb(3'b000),    "addi_aluwb");
        drive(OP_AUIPC, 1, 0, e_fetch(1, 3'b011), "auipc_fetch");
        drive(OP_AUIPC, 1, 0, e_decode(3'b011),   "auipc_decode");
        drive(OP_AUIPC, 1, 0, e_auipc(),          "auipc_exec");
        drive(OP_AUIPC, 1, 0, e_aluwb(3'b011),    "auipc_aluwb");
        check_count(32'd10, "b2b_count");
    endtask

    task automatic test_reset_mid_store();
        drive(OP_STORE, 1, 0, e_fetch(1, 3'b001), "rst_sw_fetch");
        drive(OP_STORE, 1, 0, e_decode(3'b001),   "rst_sw_decode");
        drive(OP_STORE, 1, 0, e_memadr(3'b001),   "rst_sw_memadr");
        mem_ready = 1'b0;
        exp_q.push_back(e_memwrite(0));
        name_q.push_back("rst_sw_memwrite_wait");
        compare_front();
        #2 rst_n = 1'b0;
        #1;
        check_quiet("rst_mid_store_async");
        check_count(32'd0, "rst_mid_store_count");
        @(posedge clk);
        #1;
        check_quiet("rst_mid_store_held");
        rst_n = 1'b1;
        drive(OP_STORE, 1, 0, e_fetch(1, 3'b001), "rst_sw_refetch");
        drive(OP_STORE, 1, 0, e_decode(3'b001),   "rst_sw_redecode");
        drive(OP_STORE, 1, 0, e_memadr(3'b001),   "rst_sw_rememadr");
        drive(OP_STORE, 1, 0, e_memwrite(1),      "rst_sw_rememwrite");
        check_count(32'd1, "rst_sw_count");
    endtask

    task automatic test_trap();
        drive(OP_BAD, 1, 0, e_fetch(1, 3'b000), "trap_fetch");
        drive(OP_BAD, 1, 0, e_decode(3'b000),   "trap_decode");
        for (int i = 0; i < 3; i++) begin
            drive(OP_BAD, 1, 0, e_trap(), $sformatf("trap_hold%0d", i));
        end
        check_count(32'd1, "trap_count_kept");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL trap_reset_illegal: got %b expected 0", illegal_op);
        end
        check_count(32'd0, "trap_reset_count");
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(OP_RTYPE, 1, 0, e_fetch(1, 3'b000), "trap_recover_fetch");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_stall();
        test_branch();
        test_jalr();
        test_back_to_back();
        test_reset_mid_store();
        test_trap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
